candy_id_q: RTL

Parametrised, buffered decode stage for the 24-bit candy core. Accepts raw instructions from fetch over a valid/ready handshake and decodes R/I/S/U formats into op, register addresses, register-use enables and an extended immediate. Decoded bundles are held in a DEPTH-entry queue that feeds execute over a second valid/ready handshake. Adds flush and illegal-encoding detection.

---
 rtl/candy_id_q.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/candy_id_q.sv
// ---------------------------------------------------------------------------
// candy_id_q
//
// Buffered decode stage for the 24-bit candy core. Raw instructions arrive
// from fetch over a valid/ready handshake. Each one is decoded into format,
// opcode, register addresses, register-use enables, an extended immediate and
// an illegal flag. The decoded bundle is written into a DEPTH-entry circular
// queue. The head of that queue drives execute over a second valid/ready
// handshake.
//
// Parameters
//   DEPTH  queue entries; a power of two, at least 2
//   IMM_W  width of out_imm; 16..32
//
// Build option
//   CANDY_ID_IMM_SEXT_EN  when defined, the immediate is sign-extended from
//                         its field MSB (bit 9 for I/S, bit 14 for U). When
//                         it is not defined, the immediate is zero-extended.
//                         All other fields decode the same way in both builds.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   flush        discard all queued entries and the instruction presented
//                in the same cycle
//   in_valid     fetch presents inst
//   in_ready     queue has a free entry (registered state only)
//   inst[23:0]   raw instruction
//   out_valid    head entry is valid
//   out_ready    execute accepts the head entry
//   out_type     format: R=00, I=01, S=10, U=11
//   out_op       opcode, zero-extended to 6 bits
//   out_rs1/out_rs2/out_rd           register addresses (0 when unused)
//   out_rs1_en/out_rs2_en/out_rd_en  register field used by this format
//   out_imm      extended immediate
//   out_illegal  reserved bits of the encoding were nonzero
//   count        number of occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module candy_id_q #(
  parameter int DEPTH = 2,
  parameter int IMM_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [23:0]              inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_type,
  output logic [5:0]               out_op,
  output logic [3:0]               out_rs1,
  output logic [3:0]               out_rs2,
  output logic [3:0]               out_rd,
  output logic                     out_rs1_en,
  output logic                     out_rs2_en,
  output logic                     out_rd_en,
  output logic [IMM_W-1:0]         out_imm,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_S = 2'b10;
  localparam logic [1:0] FMT_U = 2'b11;

  // One queue entry holds the fully decoded instruction. Decoding happens
  // before the queue, so the outputs never depend combinationally on inst.
  typedef struct packed {
    logic [1:0]       fmt;
    logic [5:0]       op;
    logic [3:0]       rs1;
    logic [3:0]       rs2;
    logic [3:0]       rd;
    logic             rs1_en;
    logic             rs2_en;
    logic             rd_en;
    logic [IMM_W-1:0] imm;
    logic             illegal;
  } bundle_t;

  // -------------------------------------------------------------------------
  // Immediate extension
  // -------------------------------------------------------------------------
  logic [IMM_W-1:0] imm_is;  // I/S formats: 10-bit field inst[9:0]
  logic [IMM_W-1:0] imm_u;   // U format: 15-bit field inst[14:0]

`ifdef CANDY_ID_IMM_SEXT_EN
  assign imm_is = {{(IMM_W-10){inst[9]}},  inst[9:0]};
  assign imm_u  = {{(IMM_W-15){inst[14]}}, inst[14:0]};
`else
  assign imm_is = {{(IMM_W-10){1'b0}}, inst[9:0]};
  assign imm_u  = {{(IMM_W-15){1'b0}}, inst[14:0]};
`endif

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  bundle_t dec;

  always_comb begin
    dec     = '0;
    dec.fmt = inst[23:22];
    case (inst[23:22])
      FMT_R: begin
        dec.op      = inst[21:16];
        dec.rs1     = inst[15:12];
        dec.rs2     = inst[11:8];
        dec.rd      = inst[7:4];
        dec.rs1_en  = 1'b1;
        dec.rs2_en  = 1'b1;
        dec.rd_en   = 1'b1;
        // inst[3:0] is reserved in the R format.
        dec.illegal = |inst[3:0];
      end
      FMT_I: begin
        dec.op     = {2'b00, inst[21:18]};
        dec.rs1    = inst[17:14];
        dec.rd     = inst[13:10];
        dec.rs1_en = 1'b1;
        dec.rd_en  = 1'b1;
        dec.imm    = imm_is;
      end
      FMT_S: begin
        dec.op     = {2'b00, inst[21:18]};
        dec.rs1    = inst[17:14];
        dec.rs2    = inst[13:10];
        dec.rs1_en = 1'b1;
        dec.rs2_en = 1'b1;
        dec.imm    = imm_is;
      end
      default: begin  // FMT_U
        dec.op    = {3'b000, inst[21:19]};
        dec.rd    = inst[18:15];
        dec.rd_en = 1'b1;
        dec.imm   = imm_u;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Queue control
  // -------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg,  count_next;
  logic          push;
  logic          pop;

  // in_ready depends only on the registered count. A full queue therefore
  // refuses a push even in a cycle where the head is being popped.
  assign in_ready  = (count_reg < DEPTH_C);
  assign out_valid = (count_reg != '0);

  // Flush takes priority and suppresses both handshakes.
  assign push = in_valid  && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign count = count_reg;

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // The entry array needs no reset. Stale contents are never visible because
  // every output is masked while the queue is empty.
  bundle_t mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_reg[wr_ptr_reg] <= dec;
    end
  end

  // -------------------------------------------------------------------------
  // Head output, forced to zero when no entry is valid
  // -------------------------------------------------------------------------
  bundle_t head;

  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem_reg[rd_ptr_reg];
    end
  end

  assign out_type    = head.fmt;
  assign out_op      = head.op;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_rs1_en  = head.rs1_en;
  assign out_rs2_en  = head.rs2_en;
  assign out_rd_en   = head.rd_en;
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;

endmodule
